// File: rtl/la_trg_seq.sv
// Multi-stage logic-analyzer trigger sequencer riding on a one-deep registered AXI4-stream stage.
// The triggering sample is tagged on sto_TUSER and announced by a one-cycle trg_out pulse.

module la_trg_stg #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] prv,
  input  logic          prv_vld,
  input  logic [DW-1:0] msk,
  input  logic [DW-1:0] val,
  input  logic [DW-1:0] pos,
  input  logic [DW-1:0] neg,
  output logic          hit
);
  logic lvl, edg;

  assign lvl = ((cur ^ val) & msk) == '0;
  // a stage with no edge enables is a pure level condition
  assign edg = ((pos | neg) == '0) ? 1'b1
             : prv_vld & (|((~prv & cur & pos) | (prv & ~cur & neg)));
  assign hit = lvl & edg;
endmodule

module la_trg_seq #(
  parameter  int DW = 8,
  parameter  int SN = 4,
  parameter  int CW = 16,
  localparam int NW = $clog2(SN) + 1,
  localparam int SW = (SN > 1) ? $clog2(SN) : 1
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [DW-1:0]          sti_TDATA,
  input  logic                   sti_TVALID,
  output logic                   sti_TREADY,
  output logic [DW-1:0]          sto_TDATA,
  output logic                   sto_TVALID,
  input  logic                   sto_TREADY,
  output logic                   sto_TUSER,
  input  logic                   ctl_rst,
  input  logic                   ctl_arm,
  input  logic                   ctl_trg,
  input  logic [SN-1:0][DW-1:0]  cfg_msk,
  input  logic [SN-1:0][DW-1:0]  cfg_val,
  input  logic [SN-1:0][DW-1:0]  cfg_pos,
  input  logic [SN-1:0][DW-1:0]  cfg_neg,
  input  logic [SN-1:0][CW-1:0]  cfg_cnt,
  input  logic [NW-1:0]          cfg_num,
  output logic                   sts_arm,
  output logic                   sts_trg,
  output logic [SW-1:0]          sts_stg,
  output logic [CW-1:0]          sts_occ,
  output logic                   trg_out
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] prv;
  logic          prv_vld;
  logic          pend;
  logic          xfer;
  logic [SN-1:0] hit;
  logic          hit_cur;
  logic [CW-1:0] req;
  logic [CW:0]   occ_p1;
  logic [CW-1:0] occ_sat;
  logic          adv;
  logic [NW-1:0] num_m1;
  logic [SW-1:0] lst;
  logic          last_stg;
  logic          fire;

  assign sti_TREADY = ~sto_TVALID | sto_TREADY;
  assign xfer       = sti_TVALID & sti_TREADY;
  assign sts_arm    = (state == ARMED);

  for (genvar k = 0; k < SN; k++) begin : g_stg
    la_trg_stg #(.DW(DW)) u_stg (
      .cur     (sti_TDATA),
      .prv     (prv),
      .prv_vld (prv_vld),
      .msk     (cfg_msk[k]),
      .val     (cfg_val[k]),
      .pos     (cfg_pos[k]),
      .neg     (cfg_neg[k]),
      .hit     (hit[k])
    );
  end

  always_comb begin
    hit_cur  = hit[sts_stg];
    req      = (cfg_cnt[sts_stg] == '0) ? CW'(1) : cfg_cnt[sts_stg];
    occ_p1   = {1'b0, sts_occ} + 1'b1;
    occ_sat  = (&sts_occ) ? sts_occ : sts_occ + 1'b1;
    adv      = occ_p1 >= {1'b0, req};
    // zero active stages behaves as one; oversize counts clamp to the last stage
    num_m1   = (cfg_num == '0) ? '0 : cfg_num - 1'b1;
    lst      = (num_m1 > NW'(SN - 1)) ? SW'(SN - 1) : SW'(num_m1);
    last_stg = sts_stg >= lst;
    fire     = (state == ARMED) & ~ctl_rst & ~ctl_arm & xfer
             & (ctl_trg | pend | (hit_cur & adv & last_stg));
  end

  // Output register; a transfer coinciding with ctl_rst is still forwarded so no handshake is dropped.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sto_TDATA  <= '0;
      sto_TVALID <= 1'b0;
      sto_TUSER  <= 1'b0;
    end else if (xfer) begin
      sto_TDATA  <= sti_TDATA;
      sto_TVALID <= 1'b1;
      sto_TUSER  <= fire;
    end else if (ctl_rst || sto_TREADY) begin
      sto_TVALID <= 1'b0;
      sto_TUSER  <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      prv     <= '0;
      prv_vld <= 1'b0;
      pend    <= 1'b0;
      sts_trg <= 1'b0;
      sts_stg <= '0;
      sts_occ <= '0;
      trg_out <= 1'b0;
    end else begin
      trg_out <= 1'b0;
      if (xfer) begin
        prv     <= sti_TDATA;
        prv_vld <= 1'b1;
      end
      if (ctl_rst) begin
        state   <= IDLE;
        prv_vld <= 1'b0;
        pend    <= 1'b0;
        sts_trg <= 1'b0;
        sts_stg <= '0;
        sts_occ <= '0;
      end else if (ctl_arm) begin
        state   <= ARMED;
        pend    <= 1'b0;
        sts_trg <= 1'b0;
        sts_stg <= '0;
        sts_occ <= '0;
      end else if (state == ARMED) begin
        if (ctl_trg) pend <= 1'b1;
        if (fire) begin
          state   <= DONE;
          pend    <= 1'b0;
          sts_trg <= 1'b1;
          trg_out <= 1'b1;
        end else if (xfer && hit_cur) begin
          if (adv) begin
            sts_stg <= sts_stg + 1'b1;
            sts_occ <= '0;
          end else begin
            sts_occ <= occ_sat;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_la_trg_seq.sv
// Bench for la_trg_seq: directed scenarios plus a randomized run against a transfer-level reference model.
module tb_la_trg_seq;
  localparam int DW = 8, SN = 4, CW = 16;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic [DW-1:0] sti_TDATA, sto_TDATA;
  logic sti_TVALID, sti_TREADY, sto_TVALID, sto_TREADY, sto_TUSER;
  logic ctl_rst, ctl_arm, ctl_trg;
  logic [SN-1:0][DW-1:0] cfg_msk, cfg_val, cfg_pos, cfg_neg;
  logic [SN-1:0][CW-1:0] cfg_cnt;
  logic [2:0] cfg_num;
  logic sts_arm, sts_trg, trg_out;
  logic [1:0] sts_stg;
  logic [CW-1:0] sts_occ;

  int checks = 0, errors = 0;

  // reference model state (0 idle, 1 armed, 2 done)
  int m_state, m_stg, m_occ;
  bit m_pend, m_trg, m_prvv, m_ovld, m_user, m_fire;
  logic [7:0] m_prv, m_odata;

  always #5 ACLK = ~ACLK;

  la_trg_seq #(.DW(DW), .SN(SN), .CW(CW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .sti_TDATA(sti_TDATA), .sti_TVALID(sti_TVALID), .sti_TREADY(sti_TREADY),
    .sto_TDATA(sto_TDATA), .sto_TVALID(sto_TVALID), .sto_TREADY(sto_TREADY), .sto_TUSER(sto_TUSER),
    .ctl_rst(ctl_rst), .ctl_arm(ctl_arm), .ctl_trg(ctl_trg),
    .cfg_msk(cfg_msk), .cfg_val(cfg_val), .cfg_pos(cfg_pos), .cfg_neg(cfg_neg),
    .cfg_cnt(cfg_cnt), .cfg_num(cfg_num),
    .sts_arm(sts_arm), .sts_trg(sts_trg), .sts_stg(sts_stg), .sts_occ(sts_occ),
    .trg_out(trg_out)
  );

  function automatic void m_reset();
    m_state = 0; m_stg = 0; m_occ = 0;
    m_pend = 0; m_trg = 0; m_prvv = 0; m_ovld = 0; m_user = 0; m_fire = 0;
    m_prv = 8'h00; m_odata = 8'h00;
  endfunction

  function automatic bit smatch(int k, logic [7:0] c);
    bit lvl, any_en, edge_hit;
    lvl = 1; edge_hit = 0;
    for (int b = 0; b < DW; b++) begin
      if (cfg_msk[k][b] && (c[b] != cfg_val[k][b])) lvl = 0;
      if (cfg_pos[k][b] && !m_prv[b] && c[b]) edge_hit = 1;
      if (cfg_neg[k][b] && m_prv[b] && !c[b]) edge_hit = 1;
    end
    any_en = (cfg_pos[k] != 0) || (cfg_neg[k] != 0);
    return lvl && (!any_en || (m_prvv && edge_hit));
  endfunction

  // drive one cycle starting at a negedge, advance the model, return at the next negedge
  task automatic cyc(input bit v, input logic [7:0] d, input bit ordy,
                     input bit arm = 1'b0, input bit rst = 1'b0, input bit trg = 1'b0);
    bit xfer;
    int need, lst;
    sti_TVALID = v; sti_TDATA = d; sto_TREADY = ordy;
    ctl_arm = arm; ctl_rst = rst; ctl_trg = trg;
    xfer = v && (!m_ovld || ordy);
    m_fire = 0;
    if (rst) begin
      m_state = 0; m_stg = 0; m_occ = 0; m_pend = 0; m_trg = 0;
    end else if (arm) begin
      m_state = 1; m_stg = 0; m_occ = 0; m_pend = 0; m_trg = 0;
    end else if (m_state == 1) begin
      if (trg) m_pend = 1;
      if (xfer) begin
        if (m_pend) m_fire = 1;
        else if (smatch(m_stg, d)) begin
          need = (cfg_cnt[m_stg] == 0) ? 1 : int'(cfg_cnt[m_stg]);
          lst  = (cfg_num == 0) ? 0 : int'(cfg_num) - 1;
          if (lst > SN - 1) lst = SN - 1;
          if (m_occ + 1 >= need) begin
            if (m_stg >= lst) m_fire = 1;
            else begin m_stg = m_stg + 1; m_occ = 0; end
          end else if (m_occ < 65535) m_occ = m_occ + 1;
        end
        if (m_fire) begin m_state = 2; m_trg = 1; m_pend = 0; end
      end
    end
    if (xfer) begin m_prv = d; m_odata = d; m_ovld = 1; m_user = m_fire; end
    else if (rst || ordy) begin m_ovld = 0; m_user = 0; end
    if (rst) m_prvv = 0; else if (xfer) m_prvv = 1;
    @(posedge ACLK); @(negedge ACLK);
  endtask

  task automatic cfg_single();
    cfg_msk = '0; cfg_val = '0; cfg_pos = '0; cfg_neg = '0; cfg_cnt = '0;
    cfg_num = 3'd1; cfg_msk[0] = 8'hFF; cfg_val[0] = 8'h5A; cfg_cnt[0] = 16'd1;
  endtask

  task automatic cfg_two();
    cfg_msk = '0; cfg_val = '0; cfg_pos = '0; cfg_neg = '0; cfg_cnt = '0;
    cfg_num = 3'd2;
    cfg_pos[0] = 8'h01; cfg_cnt[0] = 16'd3;
    cfg_msk[1] = 8'h80; cfg_val[1] = 8'h80; cfg_cnt[1] = 16'd1;
  endtask

  task automatic rand_cfg();
    for (int k = 0; k < SN; k++) begin
      cfg_msk[k] = 8'($urandom_range(0, 7));
      cfg_val[k] = 8'($urandom_range(0, 7));
      cfg_pos[k] = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 2)) : 8'h00;
      cfg_neg[k] = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 2)) : 8'h00;
      cfg_cnt[k] = 16'($urandom_range(0, 3));
    end
    cfg_num = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    ARESETn = 1'b0; sti_TVALID = 0; sti_TDATA = '0; sto_TREADY = 1;
    ctl_rst = 0; ctl_arm = 0; ctl_trg = 0;
    cfg_single();
    m_reset();
    repeat (2) @(negedge ACLK);
    checks++;
    if ({sto_TVALID, sto_TDATA, sto_TUSER, trg_out, sts_arm, sts_trg, sts_stg, sts_occ} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b data=%h user=%b trg=%b arm=%b st=%b stg=%0d occ=%0d, want all 0",
               sto_TVALID, sto_TDATA, sto_TUSER, trg_out, sts_arm, sts_trg, sts_stg, sts_occ);
    end
    checks++;
    if (sti_TREADY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", sti_TREADY); end
    ARESETn = 1'b1;
    // a matching sample while idle must pass through without triggering
    cyc(1, 8'h5A, 1);
    checks++;
    if ({sts_arm, trg_out, sto_TUSER, sto_TVALID, sto_TDATA} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL idle_pass: arm=%b trg=%b user=%b vld=%b data=%h, want 0 0 0 1 5a",
               sts_arm, trg_out, sto_TUSER, sto_TVALID, sto_TDATA);
    end
  endtask

  task automatic test_single_stage();
    cfg_single();
    cyc(0, 8'h00, 1, 1);
    checks++;
    if ({sts_arm, sts_trg} !== 2'b10) begin errors++; $display("FAIL arm_status: got %b%b want 10", sts_arm, sts_trg); end
    cyc(1, 8'h00, 1);
    checks++;
    if ({trg_out, sto_TUSER, sto_TDATA} !== {2'b00, 8'h00}) begin
      errors++; $display("FAIL single_nomatch: trg=%b user=%b data=%h want 0 0 00", trg_out, sto_TUSER, sto_TDATA);
    end
    cyc(1, 8'h5A, 1);
    checks++;
    if ({trg_out, sto_TUSER, sto_TDATA, sts_trg, sts_arm} !== {2'b11, 8'h5A, 2'b10}) begin
      errors++;
      $display("FAIL single_fire: trg=%b user=%b data=%h st=%b arm=%b want 1 1 5a 1 0",
               trg_out, sto_TUSER, sto_TDATA, sts_trg, sts_arm);
    end
    cyc(1, 8'h5A, 1);
    checks++;
    if ({trg_out, sto_TUSER, sts_trg} !== 3'b001) begin
      errors++; $display("FAIL single_after: trg=%b user=%b st=%b want 0 0 1", trg_out, sto_TUSER, sts_trg);
    end
  endtask

  task automatic test_two_stage();
    logic [7:0] seq [7] = '{8'h80, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80};
    bit         ef  [7] = '{0, 0, 0, 0, 0, 0, 1};
    int         es  [7] = '{0, 0, 0, 0, 0, 1, 1};
    int         eo  [7] = '{0, 1, 1, 2, 2, 0, 0};
    cfg_two();
    cyc(0, 8'h00, 1, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, seq[i], 1);
      checks++;
      if (trg_out !== ef[i] || sts_stg !== 2'(es[i]) || sts_occ !== 16'(eo[i]) || sto_TUSER !== ef[i]) begin
        errors++;
        $display("FAIL two_stage[%0d]: trg=%b user=%b stg=%0d occ=%0d want trg=%b stg=%0d occ=%0d",
                 i, trg_out, sto_TUSER, sts_stg, sts_occ, ef[i], es[i], eo[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    cfg_single();
    cyc(0, 8'h00, 1, 1);
    cyc(1, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(1, 8'h5A, 0);
    pulses = int'(trg_out);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h11, 0);
      pulses += int'(trg_out);
      checks++;
      if ({sto_TVALID, sto_TDATA, sto_TUSER, sti_TREADY} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b data=%h user=%b rdy=%b want 1 5a 1 0",
                 i, sto_TVALID, sto_TDATA, sto_TUSER, sti_TREADY);
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL bp_pulses: got %0d want 1", pulses); end
    cyc(1, 8'h11, 1);
    checks++;
    if ({sto_TVALID, sto_TDATA, sto_TUSER, trg_out} !== {1'b1, 8'h11, 2'b00}) begin
      errors++;
      $display("FAIL bp_release: vld=%b data=%h user=%b trg=%b want 1 11 0 0", sto_TVALID, sto_TDATA, sto_TUSER, trg_out);
    end
  endtask

  task automatic test_rst_arm();
    cyc(1, 8'h12, 0);
    cyc(0, 8'h00, 0, 1, 1);
    checks++;
    if ({sts_arm, sts_trg, sts_stg, sts_occ, trg_out, sto_TVALID, sto_TUSER} !== '0) begin
      errors++;
      $display("FAIL rst_arm: arm=%b st=%b stg=%0d occ=%0d trg=%b vld=%b user=%b want all 0",
               sts_arm, sts_trg, sts_stg, sts_occ, trg_out, sto_TVALID, sto_TUSER);
    end
    cyc(0, 8'h00, 1);
    checks++;
    if (sts_arm !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: arm=%b want 0", sts_arm); end
  endtask

  task automatic test_async_reset();
    cfg_two();
    cyc(0, 8'h00, 1, 1);
    cyc(1, 8'h00, 1); cyc(1, 8'h01, 1); cyc(1, 8'h00, 1);
    cyc(1, 8'h01, 1); cyc(1, 8'h00, 1); cyc(1, 8'h01, 1, 0, 0, 0);
    checks++;
    if ({sts_arm, sts_stg} !== 3'b101) begin errors++; $display("FAIL async_pre: arm=%b stg=%0d want 1 1", sts_arm, sts_stg); end
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if ({sto_TVALID, sto_TDATA, sto_TUSER, trg_out, sts_arm, sts_trg, sts_stg, sts_occ} !== '0) begin
      errors++;
      $display("FAIL async_now: vld=%b data=%h user=%b trg=%b arm=%b st=%b stg=%0d occ=%0d want all 0",
               sto_TVALID, sto_TDATA, sto_TUSER, trg_out, sts_arm, sts_trg, sts_stg, sts_occ);
    end
    m_reset();
    @(negedge ACLK);
    ARESETn = 1'b1;
    cyc(0, 8'h00, 1, 1);
    cyc(1, 8'h01, 1);
    checks++;
    if ({sts_stg, sts_occ} !== '0) begin errors++; $display("FAIL async_first_edge: stg=%0d occ=%0d want 0 0", sts_stg, sts_occ); end
    cyc(1, 8'h00, 1);
    cyc(1, 8'h01, 1);
    checks++;
    if (sts_occ !== 16'd1) begin errors++; $display("FAIL async_second_edge: occ=%0d want 1", sts_occ); end
  endtask

  task automatic test_sw_trg();
    cfg_two();
    cyc(0, 8'h00, 1, 1);
    cyc(0, 8'h00, 1, 0, 0, 1);
    checks++;
    if ({trg_out, sts_trg, sts_arm} !== 3'b001) begin
      errors++; $display("FAIL sw_trg_wait: trg=%b st=%b arm=%b want 0 0 1", trg_out, sts_trg, sts_arm);
    end
    cyc(1, 8'h00, 1);
    checks++;
    if ({trg_out, sts_trg, sto_TUSER, sts_stg} !== {3'b111, 2'd0}) begin
      errors++;
      $display("FAIL sw_trg_fire: trg=%b st=%b user=%b stg=%0d want 1 1 1 0", trg_out, sts_trg, sto_TUSER, sts_stg);
    end
  endtask

  task automatic test_random();
    logic [31:0] obs, exp;
    rand_cfg();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) rand_cfg();
      cyc($urandom_range(0, 3) != 0, 8'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0);
      obs = {sti_TREADY, sto_TVALID, sto_TVALID ? sto_TDATA : 8'h00, sto_TUSER, trg_out,
             sts_arm, sts_trg, sts_stg, sts_occ};
      exp = {(!m_ovld || sto_TREADY), m_ovld, m_ovld ? m_odata : 8'h00, m_user, m_fire,
             (m_state == 1), m_trg, 2'(m_stg), 16'(m_occ)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_stage();
    test_two_stage();
    test_backpressure();
    test_rst_arm();
    test_async_reset();
    test_sw_trg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/la_trg_seq.md
LA_TRG_SEQ -- requirements
Module: la_trg_seq

Interface
REQ-001 SHALL have parameter DW, default 8: stream sample width in bits.
REQ-002 SHALL have parameter SN, default 4: number of trigger sequence stages, 1..16.
REQ-003 SHALL have parameter CW, default 16: per-stage occurrence counter width.
REQ-004 SHALL have port ACLK, input, 1: sole clock; one clock domain throughout.
REQ-005 SHALL have port ARESETn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports sti_TDATA (input, DW), sti_TVALID (input, 1) and sti_TREADY (output, 1): input AXI4-stream.
REQ-007 SHALL have ports sto_TDATA (output, DW), sto_TVALID (output, 1), sto_TREADY (input, 1) and sto_TUSER (output, 1): output stream; TUSER=1 marks the triggering sample.
REQ-008 SHALL have ports ctl_rst, ctl_arm and ctl_trg, each input, 1: single-cycle pulses for sync clear, arm, and software trigger.
REQ-009 SHALL have ports cfg_msk, cfg_val, cfg_pos and cfg_neg, each input, SN x DW: per-stage level mask, level value, rising-edge enable and falling-edge enable.
REQ-010 SHALL have port cfg_cnt, input, SN x CW: per-stage required match count.
REQ-011 SHALL have port cfg_num, input, clog2(SN)+1: number of active stages.
REQ-012 SHALL have ports sts_arm (output, 1), sts_trg (output, 1), sts_stg (output, clog2(SN)) and sts_occ (output, CW): armed flag, triggered flag, current stage and current stage count.
REQ-013 SHALL have port trg_out, output, 1: one-cycle trigger pulse.

Function
REQ-014 SHALL register the stream through one output stage: sti_TREADY = ~sto_TVALID | sto_TREADY; on each input transfer load TDATA and set sto_TVALID; clear sto_TVALID on an output transfer with no new input.
REQ-015 SHALL hold sto_TDATA and sto_TUSER stable while sto_TVALID=1 and sto_TREADY=0; one-cycle latency; full throughput when sto_TREADY=1.
REQ-016 SHALL evaluate triggers only on input transfers (sti_TVALID & sti_TREADY), using the current sample cur and the previous transferred sample prv.
REQ-017 SHALL update prv on every input transfer in every FSM state; prv SHALL be marked invalid after reset or ctl_rst until the first transfer.
REQ-018 SHALL compute stage k level term as ((cur ^ cfg_val[k]) & cfg_msk[k]) == 0.
REQ-019 SHALL compute the stage k edge term as 1 when cfg_pos[k] and cfg_neg[k] are both zero, otherwise as prv valid AND any bit set in (~prv & cur & cfg_pos[k]) | (prv & ~cur & cfg_neg[k]).
REQ-020 SHALL define stage match as level term AND edge term.
REQ-021 SHALL implement FSM states IDLE, ARMED, DONE: IDLE -> ARMED on ctl_arm; ARMED -> DONE on trigger; DONE -> ARMED on ctl_arm.
REQ-022 SHALL, on entering ARMED, set stage = 0 and occ = 0.
REQ-023 SHALL, in ARMED on a stage-k match, increment occ; when occ+1 >= max(cfg_cnt[k],1), advance to stage k+1 with occ = 0.
REQ-024 SHALL, when the advancing stage is the last one (k == max(cfg_num,1)-1 saturated to SN-1), fire the trigger instead of advancing.
REQ-025 SHALL, on trigger fire: pulse trg_out for exactly one cycle in the cycle after the transfer, set sts_trg, go to DONE, and set sto_TUSER=1 for that sample only.
REQ-026 SHALL, on ctl_trg in ARMED, fire immediately on the next input transfer regardless of stage match.
REQ-027 SHALL apply control priority ctl_rst > ctl_arm > ctl_trg > match; ctl_arm while ARMED SHALL restart at stage 0.
REQ-028 SHALL keep occ saturated at all-ones and never wrap.
REQ-029 SHALL, on ctl_rst, return the FSM to IDLE, clear all status, invalidate prv and clear sto_TVALID, leaving the stream consistent with no sample lost mid-handshake.
REQ-030 SHALL sample configuration inputs continuously; changing them while ARMED takes effect on the next transfer.

Reset
REQ-031 SHALL, while ARESETn=0, asynchronously force: FSM to IDLE; sto_TVALID, sto_TUSER, trg_out, sts_arm and sts_trg to 0; sts_stg and sts_occ to 0; sto_TDATA to 0; prv to invalid.
REQ-032 SHALL leave IDLE only on ctl_arm after reset release.

Verification
REQ-033 SHALL cover: DW=8, 1 stage, msk=FF, val=0x5A, cnt=1, arm, stream 0x00,0x5A -> trg_out one cycle after the 0x5A transfer, TUSER=1 on 0x5A only.
REQ-034 SHALL cover: 2 stages (stage0 rising bit0 count 3, stage1 val=0x80 msk=0x80), toggle bit0 three times then send 0x80 -> fire on 0x80; 0x80 sent earlier is ignored.
REQ-035 SHALL cover: sto_TREADY held low 5 cycles during the triggering sample -> TDATA/TUSER stable, no loss, trg_out still a single pulse.
REQ-036 SHALL cover: ctl_arm and ctl_rst in the same cycle -> IDLE with all status 0.
REQ-037 SHALL cover: ARESETn asserted while ARMED at stage 1 -> all outputs 0 immediately; first sample after arm has no edge match.
REQ-038 SHALL cover: ctl_trg at stage 0 with no match -> fire on the next transfer, sts_trg=1.
